// File: rtl/vga_pkg.sv
// vga_pkg
// Shared definitions for the VGA raster timing generator and the sprite and
// palette blocks that consume its coordinates.
//   - Default 640x480 @ 60 Hz timing set (25 MHz pixel clock)
//   - coord_t  : 10-bit unsigned raster coordinate
//   - colour_t : 4-bit colour channel, rgb_t groups the three channels
//   - in_window: half-open range test used by the sync and visible decodes
package vga_pkg;

    localparam int COORD_W   = 10;
    localparam int MAX_TOTAL = 1 << COORD_W;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;

    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [3:0]         colour_t;

    typedef struct packed {
        colour_t red;
        colour_t green;
        colour_t blue;
    } rgb_t;

    // True when lo <= c < hi. Done in int so a lower bound of zero does not
    // turn into an always-true unsigned compare.
    function automatic logic in_window(input coord_t c, input int lo, input int hi);
        return (int'(c) >= lo) && (int'(c) < hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
// One raster axis: a wrapping counter plus its sync and visible decode.
// The top instantiates it once for the horizontal axis and once for the
// vertical axis, with the vertical axis advanced by the horizontal wrap.
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   advance      in   step the counter on this edge
//   count        out  registered position (0..TOTAL-1)
//   sync_n       out  registered active-low sync, aligned with count
//   next_count   out  value count takes at the next edge
//   next_visible out  visible decode of next_count
//   wrap         out  counter is stepping from TOTAL-1 to 0 this edge
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int VISIBLE = DEF_H_VISIBLE,
    parameter int FP      = DEF_H_FP,
    parameter int SYNC    = DEF_H_SYNC,
    parameter int BP      = DEF_H_BP
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               advance,
    output logic [COORD_W-1:0] count,
    output logic               sync_n,
    output logic [COORD_W-1:0] next_count,
    output logic               next_visible,
    output logic               wrap
);

    localparam int TOTAL      = VISIBLE + FP + SYNC + BP;
    localparam int SYNC_START = VISIBLE + FP;
    localparam int SYNC_END   = SYNC_START + SYNC;

    coord_t count_q, count_d;
    logic   sync_n_q, sync_n_d;
    logic   at_last;

    // The sync decode is taken from the next count so it lands on the same
    // edge as the coordinate it describes. With advance low the recomputed
    // values equal the held ones, so everything simply holds.
    always_comb begin
        at_last      = (count_q == coord_t'(TOTAL - 1));
        count_d      = count_q;
        if (advance) begin
            count_d = at_last ? '0 : count_q + 1'b1;
        end
        sync_n_d     = !in_window(count_d, SYNC_START, SYNC_END);
        next_visible = in_window(count_d, 0, VISIBLE);
        wrap         = advance && at_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            sync_n_q <= 1'b1;
        end else begin
            count_q  <= count_d;
            sync_n_q <= sync_n_d;
        end
    end

    assign count      = count_q;
    assign sync_n     = sync_n_q;
    assign next_count = count_d;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing generator for the sprite/ROM display path.
// Ports:
//   vga_clk      in   pixel clock, all logic on the rising edge
//   reset_n      in   asynchronous active-low reset
//   pix_en       in   pixel-advance enable; everything holds while low
//   DrawX        out  horizontal position (0..H_TOTAL-1)
//   DrawY        out  vertical position (0..V_TOTAL-1)
//   blank        out  1 = visible pixel, drive colour; 0 = blanking
//   hs, vs       out  active-low horizontal / vertical sync
//   line_start   out  one-cycle pulse when DrawX==0 is entered
//   frame_start  out  one-cycle pulse when (0,0) is entered
//   frame_count  out  frames completed since reset, wraps at 0xFFFF
// Every output is registered and describes the DrawX/DrawY shown in the same
// cycle, so a negedge ROM read has data ready by the next rising edge.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic               pix_en,
    output logic [COORD_W-1:0] DrawX,
    output logic [COORD_W-1:0] DrawY,
    output logic               blank,
    output logic               hs,
    output logic               vs,
    output logic               line_start,
    output logic               frame_start,
    output logic [15:0]        frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Both axes live in 10-bit counters; reject timings that cannot fit.
    generate
        if ((H_TOTAL > MAX_TOTAL) || (V_TOTAL > MAX_TOTAL)) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
    endgenerate

    coord_t h_count, h_next, v_count, v_next;
    logic   h_sync_n, v_sync_n;
    logic   h_next_visible, v_next_visible;
    logic   h_wrap, v_wrap;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FP      (H_FP),
        .SYNC    (H_SYNC),
        .BP      (H_BP)
    ) u_h_axis (
        .clk          (vga_clk),
        .rst_n        (reset_n),
        .advance      (pix_en),
        .count        (h_count),
        .sync_n       (h_sync_n),
        .next_count   (h_next),
        .next_visible (h_next_visible),
        .wrap         (h_wrap)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FP      (V_FP),
        .SYNC    (V_SYNC),
        .BP      (V_BP)
    ) u_v_axis (
        .clk          (vga_clk),
        .rst_n        (reset_n),
        .advance      (h_wrap),
        .count        (v_count),
        .sync_n       (v_sync_n),
        .next_count   (v_next),
        .next_visible (v_next_visible),
        .wrap         (v_wrap)
    );

    logic        running_q, running_d;
    logic        blank_q, blank_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic [15:0] frame_count_q, frame_count_d;

    // Pulses need an enabled advance into column 0, so a held pix_en can
    // never repeat one. The very first enabled edge moves to column 1, so no
    // pulse fires until the raster next wraps. v_wrap already implies h_wrap,
    // i.e. the single edge taking (last,last) back to (0,0).
    always_comb begin
        running_d     = running_q | pix_en;
        blank_d       = running_d & h_next_visible & v_next_visible;
        line_start_d  = pix_en & (h_next == '0);
        frame_start_d = line_start_d & (v_next == '0);
        frame_count_d = frame_count_q + {15'd0, v_wrap};
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            running_q     <= 1'b0;
            blank_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            running_q     <= running_d;
            blank_q       <= blank_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign DrawX       = h_count;
    assign DrawY       = v_count;
    assign hs          = h_sync_n;
    assign vs          = v_sync_n;
    assign blank       = blank_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule
